// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration write path.
package cfg_pkg;

    localparam int unsigned CFG_ADDR_W   = 7;
    localparam int unsigned CFG_DATA_W   = 8;
    localparam int unsigned CFG_NUM_REGS = 5;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
    } cfg_wr_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StDrain = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/cfg_commit_sched_if.sv
// Write-request handshake from the SPI register decoder into the commit scheduler.
interface cfg_commit_sched_if;
    import cfg_pkg::*;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [CFG_ADDR_W-1:0] wr_addr;
    logic [CFG_DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/cfg_wr_fifo.sv
// Small synchronous circular FIFO; push and pop in one cycle are both honoured.
module cfg_wr_fifo #(
    parameter int unsigned Width = 15,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] din_i,
    input  logic             pop_i,
    output logic [Width-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = do_push ? PtrW'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? PtrW'(rd_ptr_q + 1'b1) : rd_ptr_q;
        cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/cfg_commit_sched.sv
// Queues config writes and commits them to the live registers only at safe points.
// Optional drop_cnt output is built when CFG_COMMIT_DROP_CNT_EN is defined.
module cfg_commit_sched
    import cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS    = CFG_NUM_REGS,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned CntW       = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cfg_commit_sched_if.slave     wr,
    input  logic                  period_end,
    input  logic                  flush,
    output logic                  pending,
`ifdef CFG_COMMIT_DROP_CNT_EN
    output logic [7:0]            drop_cnt,
`endif
    output logic [CFG_DATA_W-1:0] reg_0,
    output logic [CFG_DATA_W-1:0] reg_1,
    output logic [CFG_DATA_W-1:0] reg_2,
    output logic [CFG_DATA_W-1:0] reg_3,
    output logic [CFG_DATA_W-1:0] reg_4
);

    cfg_state_e            state_q, state_d;
    logic [31:0]           tmr_q, tmr_d;
    logic [CntW-1:0]       drain_q, drain_d;
    logic [CFG_DATA_W-1:0] regs_q [CFG_NUM_REGS];
    logic [CFG_DATA_W-1:0] regs_d [CFG_NUM_REGS];

    logic            accept, addr_ok, push, pop, full, empty, trigger;
    logic [CntW-1:0] count, count_nxt;
    cfg_wr_t         head, in_wr;

    assign wr.wr_ready = !full;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign addr_ok     = 32'(wr.wr_addr) < NUM_REGS;
    assign push        = accept && addr_ok;
    assign in_wr       = '{addr: wr.wr_addr, data: wr.wr_data};
    assign pending     = (count != '0);
    assign count_nxt   = count + CntW'(push) - CntW'(pop);
    assign trigger     = period_end || flush ||
                         ((TIMEOUT_CYC != 0) && (tmr_q == TIMEOUT_CYC - 1));

    cfg_wr_fifo #(
        .Width ($bits(cfg_wr_t)),
        .Depth (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (in_wr),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        drain_d = drain_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (push) begin
                    state_d = StArmed;
                    tmr_d   = '0;
                end
            end
            StArmed: begin
                tmr_d = tmr_q + 32'd1;
                // Snapshot uses registered count, so a same-cycle push waits for the next trigger.
                if (trigger) begin
                    drain_d = count;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_q != '0) begin
                    pop     = !empty;
                    drain_d = drain_q - 1'b1;
                end
                if (drain_q <= CntW'(1)) begin
                    state_d = (count_nxt != '0) ? StArmed : StIdle;
                    tmr_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < CFG_NUM_REGS; i++) begin
            if (pop && (head.addr == CFG_ADDR_W'(i))) begin
                regs_d[i] = head.data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            drain_q <= '0;
            for (int i = 0; i < CFG_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            drain_q <= drain_d;
            regs_q  <= regs_d;
        end
    end

    assign reg_0 = regs_q[0];
    assign reg_1 = regs_q[1];
    assign reg_2 = regs_q[2];
    assign reg_3 = regs_q[3];
    assign reg_4 = regs_q[4];

`ifdef CFG_COMMIT_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop_ev;

    assign drop_ev  = (accept && !addr_ok) || (wr.wr_valid && !wr.wr_ready);
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_ev && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_cfg_commit_sched.sv
// Directed bench for cfg_commit_sched: default instance plus a TIMEOUT_CYC=16 instance.
module tb_cfg_commit_sched;
    import cfg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic period_end = 1'b0, flush = 1'b0;
    logic pe2 = 1'b0, fl2 = 1'b0;
    logic pending, pending2;
    logic [7:0] r0, r1, r2, r3, r4;
    logic [7:0] t0, t1, t2, t3, t4;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cfg_commit_sched_if bus ();
    cfg_commit_sched_if bus2 ();

`ifdef CFG_COMMIT_DROP_CNT_EN
    logic [7:0] drop_cnt, drop_cnt2;
`endif

    cfg_commit_sched dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (bus),
        .period_end (period_end),
        .flush      (flush),
        .pending    (pending),
`ifdef CFG_COMMIT_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .reg_0      (r0),
        .reg_1      (r1),
        .reg_2      (r2),
        .reg_3      (r3),
        .reg_4      (r4)
    );

    cfg_commit_sched #(.TIMEOUT_CYC(16)) dut_to (
        .clk        (clk),
        .rst        (rst),
        .wr         (bus2),
        .period_end (pe2),
        .flush      (fl2),
        .pending    (pending2),
`ifdef CFG_COMMIT_DROP_CNT_EN
        .drop_cnt   (drop_cnt2),
`endif
        .reg_0      (t0),
        .reg_1      (t1),
        .reg_2      (t2),
        .reg_3      (t3),
        .reg_4      (t4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        while (!bus.wr_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("wr_accept", 32'(bus.wr_ready), 32'd1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_pe();
        period_end = 1'b1;
        @(negedge clk);
        period_end = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus2.wr_valid = 1'b0;
        bus2.wr_addr  = '0;
        bus2.wr_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_reg0", 32'(r0), 32'h0);
        chk("rst_reg1", 32'(r1), 32'h0);
        chk("rst_reg2", 32'(r2), 32'h0);
        chk("rst_reg3", 32'(r3), 32'h0);
        chk("rst_reg4", 32'(r4), 32'h0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ready", 32'(bus.wr_ready), 32'd1);

        // Single write held until period_end
        do_write(7'd2, 8'hAA);
        repeat (50) @(negedge clk);
        chk("hold_reg2", 32'(r2), 32'h0);
        chk("hold_pending", 32'(pending), 32'd1);
        pulse_pe();
        chk("e0_reg2", 32'(r2), 32'h0);
        @(negedge clk);
        chk("e1_reg2", 32'(r2), 32'hAA);
        chk("e1_pending", 32'(pending), 32'd0);
        chk("e1_idle", 32'(dut.state_q), 32'(StIdle));

        // Fill FIFO, hold a 5th write against backpressure
        do_write(7'd0, 8'h10);
        do_write(7'd1, 8'h11);
        do_write(7'd2, 8'h12);
        do_write(7'd3, 8'h13);
        chk("full_ready", 32'(bus.wr_ready), 32'd0);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 7'd4;
        bus.wr_data  = 8'h14;
        @(negedge clk);
        chk("full_ready2", 32'(bus.wr_ready), 32'd0);
        pulse_pe();
        chk("fill_e0_reg0", 32'(r0), 32'h0);
        chk("fill_e0_ready", 32'(bus.wr_ready), 32'd0);
        @(negedge clk);
        chk("fill_e1_reg0", 32'(r0), 32'h10);
        chk("fill_e1_ready", 32'(bus.wr_ready), 32'd1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        chk("fill_e2_reg1", 32'(r1), 32'h11);
        @(negedge clk);
        chk("fill_e3_reg2", 32'(r2), 32'h12);
        @(negedge clk);
        chk("fill_e4_reg3", 32'(r3), 32'h13);
        chk("fill_e4_reg4", 32'(r4), 32'h0);
        chk("fill_e4_pending", 32'(pending), 32'd1);
        chk("fill_e4_armed", 32'(dut.state_q), 32'(StArmed));
        pulse_flush();
        @(negedge clk);
        chk("fifth_reg4", 32'(r4), 32'h14);
        chk("fifth_pending", 32'(pending), 32'd0);

        // Last write wins, applied in order
        do_write(7'd0, 8'h11);
        do_write(7'd0, 8'h22);
        pulse_flush();
        @(negedge clk);
        chk("order_first", 32'(r0), 32'h11);
        @(negedge clk);
        chk("order_last", 32'(r0), 32'h22);
        chk("order_pending", 32'(pending), 32'd0);

        // Out-of-range address: accepted and discarded
        do_write(7'd7, 8'hFF);
        chk("oor_pending", 32'(pending), 32'd0);
        chk("oor_idle", 32'(dut.state_q), 32'(StIdle));
        chk("oor_reg0", 32'(r0), 32'h22);
        chk("oor_reg4", 32'(r4), 32'h14);
        chk("oor_ready", 32'(bus.wr_ready), 32'd1);
`ifdef CFG_COMMIT_DROP_CNT_EN
        // Three stalled cycles on the held 5th write, plus this discarded write.
        chk("drop_cnt", 32'(drop_cnt), 32'd4);
`endif

        // Reset in the middle of a drain
        do_write(7'd1, 8'h31);
        do_write(7'd2, 8'h32);
        do_write(7'd3, 8'h33);
        pulse_pe();
        @(negedge clk);
        chk("mid_reg1", 32'(r1), 32'h31);
        rst = 1'b1;
        #1;
        chk("mid_rst_reg0", 32'(r0), 32'h0);
        chk("mid_rst_reg1", 32'(r1), 32'h0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_ready", 32'(bus.wr_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_reg2", 32'(r2), 32'h0);
        chk("post_rst_reg3", 32'(r3), 32'h0);
        chk("post_rst_pending", 32'(pending), 32'd0);
        chk("post_rst_idle", 32'(dut.state_q), 32'(StIdle));

        // Timeout commit on the TIMEOUT_CYC=16 instance
        bus2.wr_valid = 1'b1;
        bus2.wr_addr  = 7'd4;
        bus2.wr_data  = 8'h7F;
        chk("to_ready", 32'(bus2.wr_ready), 32'd1);
        @(negedge clk);
        bus2.wr_valid = 1'b0;
        chk("to_pending", 32'(pending2), 32'd1);
        repeat (16) @(negedge clk);
        chk("to_e16_reg4", 32'(t4), 32'h0);
        @(negedge clk);
        chk("to_e17_reg4", 32'(t4), 32'h7F);
        chk("to_e17_pending", 32'(pending2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
